mem_stage: RTL and testbench

Memory/branch-resolution stage of the 8-bit pipeline, directly downstream of the execute stage. It consumes the execute stage's ALU result, zero flag, jump target, register operand and forwarded control bits. It performs data-memory loads and stores against an internal byte RAM with configurable read latency, stalling upstream while a load is outstanding. It resolves jumps and conditional jumps for the fetch stage and registers the write-back bundle.

---
 rtl/mem_stage.sv | 139 +++++++++++++
 tb/tb_mem_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory / branch-resolution stage of the 8-bit pipeline.
// Performs data-RAM loads (with a configurable read latency that stalls
// upstream) and stores, resolves jumps for fetch, and registers the
// write-back bundle.
module mem_stage #(
  parameter int ADDR_W    = 8,
  parameter int READ_WAIT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] acOutValue,
  input  logic       zeroOut,
  input  logic [7:0] ulaJumpOut,
  input  logic [7:0] rs,
  input  logic [1:0] rdOut,
  input  logic       WRMem,
  input  logic       WMMem,
  input  logic       RMMem,
  input  logic       NEQMem,
  input  logic       JMem,
  input  logic       JCMem,
  output logic       stall,
  output logic       pcSel,
  output logic [7:0] pcTarget,
  output logic       flush,
  output logic [7:0] wbData,
  output logic [1:0] rdWB,
  output logic       WRWB
);

  typedef enum logic {IDLE, WAIT} stateT;

  // A zero READ_WAIT turns every load into a plain single-cycle access.
  localparam bit HasWait = (READ_WAIT != 0);
  localparam int WaitInitInt = HasWait ? READ_WAIT - 1 : 0;
  localparam logic [2:0] WaitInit = 3'(WaitInitInt);

  stateT             state, stateNext;
  logic [2:0]        counter, counterNext;
  logic [ADDR_W-1:0] addr, addrLatched;
  logic [7:0]        mem [2**ADDR_W];
  logic              isLoad, loadStart, retire, taken;
  logic [7:0]        readData;
  logic              unusedRs;

  // Only the low ADDR_W bits of rs address the RAM; the rest wrap away.
  assign addr     = rs[ADDR_W-1:0];
  assign unusedRs = ^rs;

  // A store takes priority when both memory strobes are set.
  assign isLoad = RMMem & ~WMMem;

  assign taken = JMem | (JCMem & (NEQMem ? ~zeroOut : zeroOut));

  // Next-state, stall and retire decode; stall is suppressed during reset.
  always_comb begin
    stateNext   = state;
    counterNext = counter;
    stall       = 1'b0;
    loadStart   = 1'b0;
    retire      = 1'b0;
    readData    = mem[addr];
    case (state)
      IDLE: begin
        if (isLoad && HasWait) begin
          loadStart   = 1'b1;
          stateNext   = WAIT;
          counterNext = WaitInit;
          stall       = 1'b1;
        end else begin
          retire = 1'b1;
        end
      end
      WAIT: begin
        readData = mem[addrLatched];
        if (counter != 3'd0) begin
          counterNext = counter - 3'd1;
          stall       = 1'b1;
        end else begin
          retire    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (reset) begin
      stall = 1'b0;
    end
  end

  // FSM state, wait counter and the address captured at load start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= 3'd0;
      addrLatched <= '0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
      if (loadStart) begin
        addrLatched <= addr;
      end
    end
  end

  // Write-back and branch outputs update only when an instruction retires;
  // stall cycles issue a bubble with no branch.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcSel    <= 1'b0;
      pcTarget <= 8'h00;
      flush    <= 1'b0;
      wbData   <= 8'h00;
      rdWB     <= 2'd0;
      WRWB     <= 1'b0;
    end else if (retire) begin
      wbData <= (isLoad || state == WAIT) ? readData : acOutValue;
      rdWB   <= rdOut;
      WRWB   <= WRMem;
      pcSel  <= taken;
      flush  <= taken;
      if (taken) begin
        pcTarget <= ulaJumpOut;
      end
    end else begin
      WRWB  <= 1'b0;
      pcSel <= 1'b0;
      flush <= 1'b0;
    end
  end

  // Data RAM write port; contents survive reset but reset blocks writes.
  always_ff @(posedge clock) begin
    if (!reset && WMMem && state == IDLE) begin
      mem[addr] <= acOutValue;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage (ADDR_W=4, READ_WAIT=2).
module tb_mem_stage;

  localparam int AW = 4;
  localparam int RW = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] acOutValue, ulaJumpOut, rs;
  logic       zeroOut;
  logic [1:0] rdOut;
  logic       WRMem, WMMem, RMMem, NEQMem, JMem, JCMem;
  logic       stall, pcSel, flush, WRWB;
  logic [7:0] pcTarget, wbData;
  logic [1:0] rdWB;

  typedef struct {
    logic [7:0] wbData;
    logic [1:0] rdWB;
    logic       WRWB;
    logic       pcSel;
    logic       flush;
    logic [7:0] pcTarget;
  } expT;

  expT        scoreboard[$];
  logic [7:0] modelMem [2**AW];
  logic [7:0] modelTarget;
  int         checkCount = 0;
  int         passCount  = 0;
  int         failCount  = 0;

  mem_stage #(.ADDR_W(AW), .READ_WAIT(RW)) dut (
    .clock(clock), .reset(reset), .acOutValue(acOutValue), .zeroOut(zeroOut),
    .ulaJumpOut(ulaJumpOut), .rs(rs), .rdOut(rdOut), .WRMem(WRMem),
    .WMMem(WMMem), .RMMem(RMMem), .NEQMem(NEQMem), .JMem(JMem), .JCMem(JCMem),
    .stall(stall), .pcSel(pcSel), .pcTarget(pcTarget), .flush(flush),
    .wbData(wbData), .rdWB(rdWB), .WRWB(WRWB)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic driveIdle();
    acOutValue = 8'h00; ulaJumpOut = 8'h00; rs = 8'h00; zeroOut = 1'b0;
    rdOut = 2'd0; WRMem = 1'b0; WMMem = 1'b0; RMMem = 1'b0;
    NEQMem = 1'b0; JMem = 1'b0; JCMem = 1'b0;
  endtask

  // Pops the oldest expectation and compares it with the registered outputs.
  task automatic checkOutput(input string tag);
    expT e;
    if (scoreboard.size() == 0) begin
      check({tag, ".queue"}, 8'd0, 8'd1);
      return;
    end
    e = scoreboard.pop_front();
    check({tag, ".wbData"},   wbData,          e.wbData);
    check({tag, ".rdWB"},     {6'd0, rdWB},    {6'd0, e.rdWB});
    check({tag, ".WRWB"},     {7'd0, WRWB},    {7'd0, e.WRWB});
    check({tag, ".pcSel"},    {7'd0, pcSel},   {7'd0, e.pcSel});
    check({tag, ".flush"},    {7'd0, flush},   {7'd0, e.flush});
    check({tag, ".pcTarget"}, pcTarget,        e.pcTarget);
  endtask

  // Drives one instruction, predicts its result from the bench model, walks
  // through any stall cycles and checks the retired write-back bundle.
  task automatic applyStimulus(input string tag, input logic rmm, input logic wmm,
                               input logic wr, input logic [1:0] rd, input logic [7:0] ac,
                               input logic [7:0] rsv, input logic j, input logic jc,
                               input logic neq, input logic z, input logic [7:0] jt);
    expT e;
    logic isTaken;
    int expStall;
    int cycles;
    acOutValue = ac; rs = rsv; rdOut = rd; WRMem = wr; WMMem = wmm; RMMem = rmm;
    JMem = j; JCMem = jc; NEQMem = neq; zeroOut = z; ulaJumpOut = jt;
    isTaken = j | (jc & (neq ? ~z : z));
    if (isTaken) modelTarget = jt;
    e.wbData   = (rmm && !wmm) ? modelMem[rsv[AW-1:0]] : ac;
    e.rdWB     = rd;
    e.WRWB     = wr;
    e.pcSel    = isTaken;
    e.flush    = isTaken;
    e.pcTarget = modelTarget;
    scoreboard.push_back(e);
    if (wmm) modelMem[rsv[AW-1:0]] = ac;
    expStall = (rmm && !wmm) ? RW : 0;
    #1;
    cycles = 0;
    while (stall === 1'b1 && cycles < 20) begin
      tick();
      cycles++;
      check({tag, ".bubbleWRWB"}, {7'd0, WRWB}, 8'd0);
    end
    check({tag, ".stallCycles"}, 8'(cycles), 8'(expStall));
    tick();
    checkOutput(tag);
  endtask

  initial begin
    modelTarget = 8'h00;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      acOutValue = 8'($urandom); ulaJumpOut = 8'($urandom); rs = 8'($urandom);
      zeroOut = 1'($urandom); rdOut = 2'($urandom); WRMem = 1'($urandom);
      WMMem = 1'($urandom); RMMem = 1'($urandom); NEQMem = 1'($urandom);
      JMem = 1'($urandom); JCMem = 1'($urandom);
      tick();
    end
    check("reset.stall",    {7'd0, stall}, 8'd0);
    check("reset.pcSel",    {7'd0, pcSel}, 8'd0);
    check("reset.pcTarget", pcTarget,      8'h00);
    check("reset.flush",    {7'd0, flush}, 8'd0);
    check("reset.wbData",   wbData,        8'h00);
    check("reset.rdWB",     {6'd0, rdWB},  8'd0);
    check("reset.WRWB",     {7'd0, WRWB},  8'd0);
    reset = 1'b0;
    driveIdle();

    // store then load back, same address
    applyStimulus("store",    0, 1, 0, 2'd0, 8'hA5, 8'h10, 0, 0, 0, 0, 8'h00);
    applyStimulus("load",     1, 0, 1, 2'd2, 8'h00, 8'h10, 0, 0, 0, 0, 8'h00);
    // conditional branches
    applyStimulus("bzTaken",  0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h3C);
    applyStimulus("bnzNot",   0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 1, 1, 1, 8'h55);
    applyStimulus("jBoth",    0, 0, 0, 2'd3, 8'h12, 8'h00, 1, 1, 0, 0, 8'h44);
    // ALU pass-through
    applyStimulus("aluPass",  0, 0, 1, 2'd1, 8'h7E, 8'h00, 0, 0, 0, 0, 8'h00);
    // back-to-back loads, second one carrying a jump
    applyStimulus("store2",   0, 1, 0, 2'd0, 8'h39, 8'h05, 0, 0, 0, 0, 8'h00);
    applyStimulus("loadB2B1", 1, 0, 1, 2'd3, 8'h00, 8'h05, 0, 0, 0, 0, 8'h00);
    applyStimulus("loadB2B2", 1, 0, 1, 2'd1, 8'h00, 8'h10, 1, 0, 0, 0, 8'h80);

    // reset in the first WAIT cycle aborts the load
    rs = 8'h10; RMMem = 1'b1; WRMem = 1'b1; rdOut = 2'd3;
    tick();
    check("midLoad.stall", {7'd0, stall}, 8'd1);
    reset = 1'b1;
    driveIdle();
    tick();
    reset = 1'b0;
    #1;
    check("abort.stall",    {7'd0, stall}, 8'd0);
    check("abort.WRWB",     {7'd0, WRWB},  8'd0);
    check("abort.pcTarget", pcTarget,      8'h00);
    check("abort.wbData",   wbData,        8'h00);
    modelTarget = 8'h00;
    applyStimulus("loadAfterRst", 1, 0, 1, 2'd2, 8'h00, 8'h10, 0, 0, 0, 0, 8'h00);

    // address wrap and store/load conflict
    applyStimulus("wrapStore",  0, 1, 0, 2'd0, 8'h11, 8'h23, 0, 0, 0, 0, 8'h00);
    applyStimulus("wrapLoad",   1, 0, 1, 2'd1, 8'h00, 8'h03, 0, 0, 0, 0, 8'h00);
    applyStimulus("conflict",   1, 1, 1, 2'd2, 8'h5A, 8'h07, 0, 0, 0, 0, 8'h00);
    applyStimulus("conflictRd", 1, 0, 1, 2'd0, 8'h00, 8'h17, 0, 0, 0, 0, 8'h00);
    driveIdle();
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
